// File: rtl/m_seq.sv
// m_seq: instruction sequencer feeding the m_acc accumulator operand.
// Fetches 8-bit words over req/ack and drives data for one EXEC cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      run pulse, honoured only in IDLE or HALT
//   acc_in     accumulator value fed back from m_acc
//   mem_rdata  memory read data, valid with mem_ack
//   mem_ack    memory acknowledge
//   mem_req    memory read request
//   mem_addr   memory word address
//   data       registered operand to m_acc (zero outside EXEC)
//   pc         program counter
//   busy       high outside IDLE and HALT
//   halted     high in HALT
module m_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] acc_in,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic [4:0] mem_addr,
    output logic [7:0] data,
    output logic [4:0] pc,
    output logic       busy,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPER,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUBI = 3'b010;
    localparam logic [2:0] OP_LDI  = 3'b011;
    localparam logic [2:0] OP_ADDM = 3'b100;
    localparam logic [2:0] OP_JMP  = 3'b101;
    localparam logic [2:0] OP_JZ   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t     state;
    state_t     state_n;
    logic [4:0] pc_n;
    logic [7:0] ir;
    logic [7:0] ir_n;
    logic [7:0] data_n;

    logic [2:0] opc;
    logic [4:0] fld;
    logic [7:0] imm;

    assign opc = ir[7:5];
    assign fld = ir[4:0];
    assign imm = {3'b000, fld};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            ir    <= '0;
            data  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            data  <= data_n;
        end
    end

    // data_n defaults to zero so the operand register is only
    // non-zero for the single cycle spent in EXEC.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        data_n  = '0;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n    = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_n    = mem_rdata;
                    pc_n    = pc + 5'd1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                state_n = S_FETCH;
                unique case (opc)
                    OP_NOP: begin
                        state_n = S_FETCH;
                    end
                    OP_ADDI: begin
                        data_n  = imm;
                        state_n = S_EXEC;
                    end
                    OP_SUBI: begin
                        data_n  = ~imm + 8'd1;
                        state_n = S_EXEC;
                    end
                    OP_LDI: begin
                        // adding imm - acc leaves the accumulator at imm
                        data_n  = imm - acc_in;
                        state_n = S_EXEC;
                    end
                    OP_ADDM: begin
                        state_n = S_OPER;
                    end
                    OP_JMP: begin
                        pc_n = fld;
                    end
                    OP_JZ: begin
                        if (acc_in == 8'd0) begin
                            pc_n = fld;
                        end
                    end
                    OP_HALT: begin
                        state_n = S_HALT;
                    end
                endcase
            end
            S_OPER: begin
                if (mem_ack) begin
                    data_n  = mem_rdata;
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                state_n = S_FETCH;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Request lines depend on registered state only, so they are
    // stable for the whole wait and drop as soon as reset hits.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        busy     = 1'b1;
        halted   = 1'b0;
        unique case (1'b1)
            state == S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            state == S_OPER: begin
                mem_req  = 1'b1;
                mem_addr = fld;
            end
            state == S_IDLE: begin
                busy = 1'b0;
            end
            state == S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

endmodule
